// File: rtl/mbist_fail_logger.sv
// rtl/mbist_fail_logger.sv - March read response analysis with fault-log FIFO
module mbist_fail_logger #(
   parameter int AW        = 8,
   parameter int DW        = 4,
   parameter int RD_LAT    = 1,
   parameter int LOG_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_in,
   input  logic          cmp_en,
   input  logic [AW-1:0] addr_in,
   input  logic [DW-1:0] exp_dat,
   input  logic [DW-1:0] rd_dat,
   input  logic          test_done,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [7:0]    fail_cnt,
   output logic          log_ovf,
   output logic          log_vld,
   output logic [AW-1:0] log_addr,
   output logic [DW-1:0] log_syn,
   input  logic          log_pop
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int PW = $clog2(LOG_DEPTH) + 1;
   localparam int IW = PW - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      drain_cnt_q;
   logic            start;
   logic            in_run;

   logic [RD_LAT-1:0] pv_q;
   logic [AW-1:0]     pa_q [RD_LAT];
   logic [DW-1:0]     pe_q [RD_LAT];

   logic [DW-1:0]   syn;
   logic            mismatch;

   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW-1:0]   mem_addr_q [LOG_DEPTH];
   logic [DW-1:0]   mem_syn_q  [LOG_DEPTH];
   logic            fifo_empty, fifo_full;
   logic            pop_ok, push_ok, ovf_hit;

   logic [7:0]      fail_cnt_q, fail_cnt_d;
   logic            ovf_q, ovf_d;
   logic            pass_q, pass_d;

   assign start  = (state_q == S_IDLE) && en_in;
   assign in_run = (state_q == S_RUN);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: abort beats completion in RUN; DRAIN always retires its in-flight reads.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (en_in) state_d = S_RUN;
         S_RUN: begin
            if (!en_in)         state_d = S_IDLE;
            else if (test_done) state_d = S_DRAIN;
         end
         S_DRAIN: if (drain_cnt_q == 2'(RD_LAT - 1)) state_d = S_DONE;
         S_DONE:  if (!en_in) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Cycles spent in DRAIN, used to let the last RD_LAT compares retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt_q <= 2'd0;
      end else if (state_q != S_DRAIN) begin
         drain_cnt_q <= 2'd0;
      end else begin
         drain_cnt_q <= drain_cnt_q + 2'd1;
      end
   end

   // Alignment pipeline: a read launched in RUN reaches the last stage when its data arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pa_q[i] <= '0;
            pe_q[i] <= '0;
         end
      end else if (start) begin
         pv_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pa_q[i] <= '0;
            pe_q[i] <= '0;
         end
      end else begin
         pv_q[0] <= cmp_en && in_run;
         if (in_run) begin
            pa_q[0] <= addr_in;
            pe_q[0] <= exp_dat;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pe_q[i] <= pe_q[i-1];
         end
      end
   end

   // Compare at the pipeline output and derive FIFO handshakes.
   always_comb begin
      syn        = pe_q[RD_LAT-1] ^ rd_dat;
      mismatch   = pv_q[RD_LAT-1] && (syn != '0);
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
      pop_ok     = log_pop && !fifo_empty;
      push_ok    = mismatch && (!fifo_full || pop_ok);
      ovf_hit    = mismatch && fifo_full && !pop_ok;
   end

   // FIFO pointers; a new run discards the previous log.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (start) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // FIFO storage; cleared on reset so the head reads zero before any push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LOG_DEPTH; i++) begin
            mem_addr_q[i] <= '0;
            mem_syn_q[i]  <= '0;
         end
      end else if (push_ok && !start) begin
         mem_addr_q[wr_ptr_q[IW-1:0]] <= pa_q[RD_LAT-1];
         mem_syn_q[wr_ptr_q[IW-1:0]]  <= syn;
      end
   end

   // Counter, overflow and verdict next-state; pass sees the compare retiring on the DONE edge.
   always_comb begin
      fail_cnt_d = fail_cnt_q;
      ovf_d      = ovf_q;
      pass_d     = 1'b0;
      if (start) begin
         fail_cnt_d = 8'd0;
         ovf_d      = 1'b0;
      end else begin
         if (mismatch && (fail_cnt_q != 8'hFF)) fail_cnt_d = fail_cnt_q + 8'd1;
         if (ovf_hit) ovf_d = 1'b1;
      end
      if (state_d == S_DONE) begin
         pass_d = (state_q == S_DONE) ? pass_q : ((fail_cnt_d == 8'd0) && !ovf_d);
      end
   end

   // Result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_cnt_q <= 8'd0;
         ovf_q      <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         fail_cnt_q <= fail_cnt_d;
         ovf_q      <= ovf_d;
         pass_q     <= pass_d;
      end
   end

   assign pass     = pass_q;
   assign fail_cnt = fail_cnt_q;
   assign log_ovf  = ovf_q;
   assign log_vld  = !fifo_empty;
   assign log_addr = mem_addr_q[rd_ptr_q[IW-1:0]];
   assign log_syn  = mem_syn_q[rd_ptr_q[IW-1:0]];

endmodule
